// File: rtl/axi_wr_burst_master.sv
// axi_wr_burst_master: pops words from a sync FIFO and writes them out as AXI4 INCR bursts.
// Optional feature macro DMA_WR_ABORT_EN: a non-OKAY write response ends the transfer early.
module axi_wr_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic [LEN_W-1:0]  xfer_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DW-1:0]     fifo_dout,
  output logic [AW-1:0]     m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DW-1:0]     m_wdata,
  output logic [DW/8-1:0]   m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  localparam int BPB = DW / 8;
  localparam int BSZ = $clog2(BPB);
  localparam int CW  = ((LEN_W > 13) ? LEN_W : 13) + 1;

`ifdef DMA_WR_ABORT_EN
  localparam bit ABORT_ON_ERR = 1'b1;
`else
  localparam bit ABORT_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     addr_reg;
  logic [AW-1:0]     awaddr_reg;
  logic [7:0]        awlen_reg;
  logic [LEN_W-1:0]  remaining_reg;
  logic [8:0]        reads_left_reg;
  logic [8:0]        wr_left_reg;
  logic              err_reg;
  logic [DW-1:0]     buf_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              inflight_reg;

  logic [AW-1:0]     calc_addr;
  logic [LEN_W-1:0]  calc_rem;
  logic [12:0]       room_beats;
  logic [CW-1:0]     len_min;
  logic [8:0]        calc_len;
  logic              load_aw, aw_hs, w_pop, b_hs, b_bad, rd_en, accept;
  logic [2:0]        occupancy;

  // Next burst is sized from the start inputs when leaving IDLE, otherwise from the running address.
  always_comb begin
    calc_addr  = (state_reg == S_IDLE) ? (start_addr & ~AW'(BPB - 1)) : addr_reg;
    calc_rem   = (state_reg == S_IDLE) ? xfer_beats : remaining_reg;
    room_beats = (13'd4096 - {1'b0, calc_addr[11:0]}) >> BSZ;
    len_min    = CW'(calc_rem);
    if (CW'(room_beats) < len_min) len_min = CW'(room_beats);
    if (CW'(MAX_BURST) < len_min)  len_min = CW'(MAX_BURST);
    calc_len   = len_min[8:0];
  end

  assign m_awvalid = (state_reg == S_ADDR);
  assign m_awaddr  = awaddr_reg;
  assign m_awlen   = awlen_reg;
  assign m_awsize  = 3'(BSZ);
  assign m_awburst = 2'b01;
  assign m_wstrb   = '1;
  assign m_wvalid  = (state_reg == S_DATA) && (count_reg != 2'd0);
  assign m_wdata   = buf_mem[rd_ptr_reg];
  assign m_wlast   = m_wvalid && (wr_left_reg == 9'd1);
  assign m_bready  = (state_reg == S_RESP);
  assign busy      = (state_reg == S_ADDR) || (state_reg == S_DATA) || (state_reg == S_RESP);
  assign done      = (state_reg == S_FIN);
  assign err       = err_reg;

  assign accept  = (state_reg == S_IDLE) && start;
  assign aw_hs   = m_awvalid && m_awready;
  assign w_pop   = m_wvalid && m_wready;
  assign b_hs    = m_bready && m_bvalid;
  assign b_bad   = (m_bresp != 2'b00);
  assign load_aw = (state_next == S_ADDR) && (state_reg != S_ADDR);

  // Words already staged plus the one in flight from the FIFO must never exceed two.
  assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, w_pop};
  assign rd_en      = (state_reg == S_DATA) && !fifo_empty && (reads_left_reg != 9'd0)
                      && (occupancy < 3'd2);
  assign fifo_rd_en = rd_en;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = (xfer_beats == '0) ? S_FIN : S_ADDR;
      S_ADDR: if (m_awready) state_next = S_DATA;
      S_DATA: if (w_pop && m_wlast) state_next = S_RESP;
      S_RESP: if (m_bvalid) begin
        state_next = (remaining_reg == '0) ? S_FIN : S_ADDR;
        if (ABORT_ON_ERR && b_bad) state_next = S_FIN;
      end
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg       <= '0;
      awaddr_reg     <= '0;
      awlen_reg      <= '0;
      remaining_reg  <= '0;
      reads_left_reg <= '0;
      wr_left_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (accept)
        err_reg <= 1'b0;
      else if (b_hs && b_bad)
        err_reg <= 1'b1;

      if (accept)
        remaining_reg <= xfer_beats;
      else if (aw_hs)
        remaining_reg <= remaining_reg - (LEN_W'(awlen_reg) + LEN_W'(1));

      if (aw_hs)
        addr_reg <= awaddr_reg + ((AW'(awlen_reg) + AW'(1)) << BSZ);

      if (load_aw) begin
        awaddr_reg     <= calc_addr;
        awlen_reg      <= 8'(calc_len - 9'd1);
        reads_left_reg <= calc_len;
        wr_left_reg    <= calc_len;
      end else begin
        if (rd_en) reads_left_reg <= reads_left_reg - 9'd1;
        if (w_pop) wr_left_reg    <= wr_left_reg - 9'd1;
      end
    end
  end

  // Two-entry staging buffer absorbs the FIFO's one-cycle read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_mem[0]   <= '0;
      buf_mem[1]   <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      count_reg    <= occupancy[1:0];
      if (inflight_reg) begin
        buf_mem[wr_ptr_reg] <= fifo_dout;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (w_pop) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master: FIFO source model, AXI slave model, data/burst scoreboards.
module tb_axi_wr_burst_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] xfer_beats;
  logic          busy, done, err;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid, m_awready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;

  axi_wr_burst_master #(.DW(DW), .AW(AW), .MAX_BURST(MB), .LEN_W(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .xfer_beats(xfer_beats),
    .busy(busy), .done(done), .err(err),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_data_q[$];
  logic [39:0] exp_aw_q[$];
  logic [39:0] aw_log[$];

  int aw_delay = 0;
  bit wr_rand = 0;
  bit gaps = 0;
  int err_burst = -1;
  int burst_idx = 0;
  int done_cnt = 0;
  int n_rd = 0;
  int n_awv = 0;
  int exp_pops_v = 0;

  int          aw_wait = 0;
  bit          aw_ok = 0;
  bit          pend_valid = 0;
  logic [31:0] pend_data;
  bit          hold_w = 0;
  logic [31:0] hold_wdata;
  logic        hold_wlast;
  bit          hold_aw = 0;
  logic [39:0] hold_awv;
  bit          b_pend = 0;
  int          beat = 0;
  int          cur_len = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO source and AXI slave: inputs change on negedge, outputs sampled 1ns later.
  initial begin
    logic [39:0] exp_aw;
    logic [31:0] exp_d;
    fifo_dout = '0; fifo_empty = 1'b1; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (pend_valid) begin fifo_dout = pend_data; pend_valid = 0; end
      fifo_empty = (src_q.size() == 0) || (gaps && ($urandom_range(0, 2) == 0));
      m_wready   = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_awready  = m_awvalid && (aw_wait >= aw_delay);
      m_bvalid   = b_pend;
      m_bresp    = (b_pend && (burst_idx == err_burst)) ? 2'b10 : 2'b00;
      #1;
      if (!rstn) begin
        pend_valid = 0; aw_ok = 0; b_pend = 0; aw_wait = 0; hold_w = 0; hold_aw = 0; beat = 0;
      end else begin
        if (done) done_cnt++;
        if (fifo_rd_en) begin
          n_rd++;
          check("rd_while_empty", 64'(fifo_empty), 64'(0));
          if (src_q.size() != 0) begin pend_data = src_q.pop_front(); pend_valid = 1; end
        end
        if (m_awvalid) begin
          n_awv++;
          if (hold_aw) check("aw_stable", 64'({m_awaddr, m_awlen}), 64'(hold_awv));
          if (m_awready) begin
            check("aw_expected", 64'(exp_aw_q.size() != 0), 64'(1));
            if (exp_aw_q.size() != 0) begin
              exp_aw = exp_aw_q.pop_front();
              check("aw_addr_len", 64'({m_awaddr, m_awlen}), 64'(exp_aw));
            end
            aw_log.push_back({m_awaddr, m_awlen});
            cur_len = int'(m_awlen) + 1;
            aw_ok = 1; aw_wait = 0; hold_aw = 0; beat = 0;
          end else begin
            aw_wait++; hold_aw = 1; hold_awv = {m_awaddr, m_awlen};
          end
        end
        if (m_wvalid) begin
          check("w_after_aw", 64'(aw_ok), 64'(1));
          if (hold_w) check("w_stable", 64'({m_wlast, m_wdata}), 64'({hold_wlast, hold_wdata}));
          if (m_wready) begin
            hold_w = 0;
            check("w_expected", 64'(exp_data_q.size() != 0), 64'(1));
            exp_d = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 32'hDEAD_BEEF;
            beat++;
            $display("W beat %0d data=0x%0h last=%0b", beat, m_wdata, m_wlast);
            check("wdata", 64'(m_wdata), 64'(exp_d));
            check("wlast", 64'(m_wlast), 64'(beat == cur_len));
            if (m_wlast) begin b_pend = 1; aw_ok = 0; beat = 0; end
          end else begin
            hold_w = 1; hold_wdata = m_wdata; hold_wlast = m_wlast;
          end
        end else if (hold_w) begin
          check("w_held_valid", 64'(m_wvalid), 64'(1));
          hold_w = 0;
        end
        if (m_bvalid && m_bready) begin b_pend = 0; burst_idx++; end
      end
    end
  end

  // Build the expected bursts and data, then pulse start.
  task automatic setup_xfer(input logic [31:0] addr, input int beats, input int base,
                            input int awd, input bit wr, input bit gp, input int eb);
    logic [31:0] a;
    int rem, L, d, nb;
    bit stop;
    src_q.delete(); exp_data_q.delete(); exp_aw_q.delete(); aw_log.delete();
    for (int i = 0; i < beats; i++) src_q.push_back(32'(base + i));
    a = addr & 32'hFFFF_FFFC; rem = beats; d = 0; nb = 0; stop = 0; exp_pops_v = 0;
    while (rem > 0 && !stop) begin
      L = rem;
      if (L > MB) L = MB;
      if ((4096 - int'(a[11:0])) / 4 < L) L = (4096 - int'(a[11:0])) / 4;
      exp_aw_q.push_back({a, 8'(L - 1)});
      for (int j = 0; j < L; j++) exp_data_q.push_back(32'(base + d + j));
      d += L; exp_pops_v += L; a = a + 32'(L * 4); rem -= L;
`ifdef DMA_WR_ABORT_EN
      if (nb == eb) stop = 1;
`endif
      nb++;
    end
    aw_delay = awd; wr_rand = wr; gaps = gp; err_burst = eb;
    burst_idx = 0; done_cnt = 0; n_rd = 0; n_awv = 0;
    @(negedge clk);
    start_addr = addr; xfer_beats = LW'(beats); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int done_lat = 0;

  task automatic finish_xfer(input string tag, input bit exp_err);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk); #2; cyc++;
    end
    done_lat = cyc;
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    repeat (3) @(negedge clk);
    #2;
    $display("%s: bursts=%0d pops=%0d done_latency=%0d err=%0b", tag, aw_log.size(), n_rd, done_lat, err);
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_pops"}, 64'(n_rd), 64'(exp_pops_v));
    check({tag, "_data_left"}, 64'(exp_data_q.size()), 64'(0));
    check({tag, "_aw_left"}, 64'(exp_aw_q.size()), 64'(0));
    check({tag, "_busy_low"}, 64'(busy), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'(0));
    check({tag, "_aw"}, 64'({m_awvalid, m_awaddr, m_awlen}), 64'(0));
    check({tag, "_awconst"}, 64'({m_awsize, m_awburst, m_wstrb}), 64'({3'd2, 2'b01, 4'hF}));
    check({tag, "_w"}, 64'({m_wvalid, m_wlast, m_wdata}), 64'(0));
    check({tag, "_bready"}, 64'(m_bready), 64'(0));
  endtask

  initial begin
    int cyc;
    rstn = 1'b0; start = 1'b0; start_addr = '0; xfer_beats = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // 1: three bursts 16/16/8 from 0x1000
    setup_xfer(32'h1000, 40, 0, 0, 0, 0, -1);
    finish_xfer("t1", 1'b0);
    check("t1_nbursts", 64'(aw_log.size()), 64'(3));
    if (aw_log.size() == 3) begin
      check("t1_b0", 64'(aw_log[0]), 64'({32'h1000, 8'd15}));
      check("t1_b1", 64'(aw_log[1]), 64'({32'h1040, 8'd15}));
      check("t1_b2", 64'(aw_log[2]), 64'({32'h1080, 8'd7}));
    end

    // 2: split at the 4KB boundary
    setup_xfer(32'h0FF0, 8, 1000, 0, 0, 0, -1);
    finish_xfer("t2", 1'b0);
    check("t2_nbursts", 64'(aw_log.size()), 64'(2));
    if (aw_log.size() == 2) begin
      check("t2_b0", 64'(aw_log[0]), 64'({32'h0FF0, 8'd3}));
      check("t2_b1", 64'(aw_log[1]), 64'({32'h1000, 8'd3}));
    end

    // 3: slow awready, random wready, FIFO empty gaps
    setup_xfer(32'h2000, 24, 2000, 5, 1, 1, -1);
    finish_xfer("t3", 1'b0);

    // 4: SLVERR on the first burst
    setup_xfer(32'h3000, 48, 3000, 0, 1, 0, 0);
    finish_xfer("t4", 1'b1);
`ifdef DMA_WR_ABORT_EN
    check("t4_nbursts", 64'(aw_log.size()), 64'(1));
`else
    check("t4_nbursts", 64'(aw_log.size()), 64'(3));
`endif

    // 5: zero-beat transfer, then a start while busy
    setup_xfer(32'h0100, 0, 0, 0, 0, 0, -1);
    finish_xfer("t5", 1'b0);
    check("t5_done_latency_ok", 64'(done_lat <= 2), 64'(1));
    check("t5_no_awvalid", 64'(n_awv), 64'(0));
    setup_xfer(32'h5000, 4, 4000, 5, 0, 0, -1);
    @(negedge clk);
    #2;
    check("t5b_busy", 64'(busy), 64'(1));
    start_addr = 32'h9000; xfer_beats = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_xfer("t5b", 1'b0);
    check("t5b_nbursts", 64'(aw_log.size()), 64'(1));

    // 6: reset in the middle of the data phase
    setup_xfer(32'h6000, 16, 5000, 0, 1, 0, -1);
    cyc = 0;
    while (!m_wvalid && cyc < 200) begin @(negedge clk); #2; cyc++; end
    check("t6_reached_data", 64'(m_wvalid), 64'(1));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rstn = 1'b1;
    setup_xfer(32'h7000, 4, 6000, 0, 0, 0, -1);
    finish_xfer("t6_after", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
